load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_align.sv | 42 ++++
 rtl/load_store_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: RV32I width codes, FSM states,
// and the funct3 legality check used at request acceptance.
package lsu_pkg;

   localparam int WORD_BYTES = 4;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_RSP  = 2'd3
   } lsu_state_e;

   // Stores only have signed width codes; the unsigned forms are load-only.
   function automatic logic funct3_ok(input logic we, input logic [2:0] f3);
      logic ok;
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      if (!we)
         ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
      return ok;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: extracts and extends load data from a memory word and
// merges store data into the addressed lanes of a previously read word.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] store_o
);

   logic [4:0]  sh;
   logic [31:0] shifted;
   logic [31:0] mask;

   assign sh      = {off_i, 3'b000};
   assign shifted = word_i >> sh;

   always_comb begin
      load_o = word_i;
      case (funct3_i)
         F3_B:    load_o = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    load_o = {{16{shifted[15]}}, shifted[15:0]};
         F3_BU:   load_o = {24'd0, shifted[7:0]};
         F3_HU:   load_o = {16'd0, shifted[15:0]};
         default: load_o = word_i;
      endcase
   end

   always_comb begin
      mask = 32'hFFFF_FFFF;
      case (funct3_i)
         F3_B:    mask = 32'h0000_00FF << sh;
         F3_H:    mask = 32'h0000_FFFF << sh;
         default: mask = 32'hFFFF_FFFF;
      endcase
      store_o = (word_i & ~mask) | ((wdata_i << sh) & mask);
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: single-outstanding FSM driving a word-wide memory.
// Optional LSU_MISALIGN_TRAP_EN rejects misaligned H/W accesses instead of aligning them.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int WORDS = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic [31:0] mem_rdata
);

   localparam logic [29:0] WORDS_IDX = 30'(WORDS);

   lsu_state_e  state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  f3_q, f3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] word_q, word_d;
   logic        err_q, err_d;

   logic        range_bad;
   logic        misaligned;
   logic        req_bad;
   logic [31:0] addr_aligned;
   logic [31:0] load_word;
   logic [31:0] store_word;

   assign range_bad = (req_addr[31:2] >= WORDS_IDX);

   always_comb begin
      misaligned   = 1'b0;
      addr_aligned = req_addr;
      case (req_funct3[1:0])
         2'b01: begin
            misaligned      = req_addr[0];
            addr_aligned[0] = 1'b0;
         end
         2'b10: begin
            misaligned        = (req_addr[1:0] != 2'b00);
            addr_aligned[1:0] = 2'b00;
         end
         default: ;
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   assign req_bad = range_bad || !funct3_ok(req_we, req_funct3) || misaligned;
`else
   assign req_bad = range_bad || !funct3_ok(req_we, req_funct3);
`endif

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      word_d  = word_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               f3_d    = req_funct3;
               wdata_d = req_wdata;
               err_d   = req_bad;
`ifdef LSU_MISALIGN_TRAP_EN
               addr_d  = req_addr;
`else
               addr_d  = addr_aligned;
`endif
               if (req_bad)
                  state_d = ST_RSP;
               else if (req_we && (req_funct3 == F3_W))
                  state_d = ST_WR;
               else
                  state_d = ST_RD;
            end
         end
         ST_RD: begin
            // Sub-word stores go on to WR to write back the merged word.
            word_d  = mem_rdata;
            state_d = we_q ? ST_WR : ST_RSP;
         end
         ST_WR: state_d = ST_RSP;
         ST_RSP: begin
            err_d   = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         word_q  <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         word_q  <= word_d;
         err_q   <= err_d;
      end
   end

   lsu_align u_align (
      .word_i   (word_q),
      .off_i    (addr_q[1:0]),
      .funct3_i (f3_q),
      .wdata_i  (wdata_q),
      .load_o   (load_word),
      .store_o  (store_word)
   );

   // Strobe is masked by rst so a reset landing in WR never commits the write.
   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RSP);
   assign rsp_err   = (state_q == ST_RSP) && err_q;
   assign rsp_rdata = ((state_q == ST_RSP) && !we_q && !err_q) ? load_word : 32'd0;
   assign mem_addr  = ((state_q == ST_RD) || (state_q == ST_WR)) ? {2'b00, addr_q[31:2]} : 32'd0;
   assign mem_we    = (state_q == ST_WR) && !rst;
   assign mem_wdata = (state_q == ST_WR) ? store_word : 32'd0;

endmodule
